// File: rtl/main_mem_arbiter.sv
// Two-port weighted arbiter for the single-port main data RAM. Port 0 is the processor and port 1
// is the debug/monitor reader. Commands are registered toward the RAM, and read data returns through a tag pipe.
module main_mem_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int WEIGHT0 = 3,
    parameter int RD_LAT  = 1
) (
    input  logic          clock,
    input  logic          n_reset,
    input  logic          req0,
    input  logic          wren0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          wren1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_data,
    output logic          m_wren,
    input  logic [DW-1:0] m_q
);

    localparam int SW = (WEIGHT0 < 1) ? 1 : $clog2(WEIGHT0 + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(WEIGHT0);

    logic [SW-1:0]   streak_q, streak_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_wren_q, m_wren_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [RD_LAT:0] tvld_q, tvld_d;
    logic [RD_LAT:0] tport_q, tport_d;

    logic xfer0, xfer1, rd_accept;

    // Grant: port 0 wins until its streak against a waiting port 1 reaches WEIGHT0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (n_reset) begin
            if (req0 && (!req1 || (streak_q < STREAK_MAX))) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        xfer0     = req0 & gnt0;
        xfer1     = req1 & gnt1;
        rd_accept = (xfer0 & ~wren0) | (xfer1 & ~wren1);
    end

    always_comb begin
        streak_d = streak_q;
        if (!req1 || xfer1) begin
            streak_d = '0;
        end else if (xfer0 && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // Command stage: address and data hold when idle, write enable drops.
    always_comb begin
        m_addr_d = m_addr_q;
        m_data_d = m_data_q;
        m_wren_d = 1'b0;
        if (xfer0) begin
            m_addr_d = addr0;
            m_data_d = wdata0;
            m_wren_d = wren0;
        end else if (xfer1) begin
            m_addr_d = addr1;
            m_data_d = wdata1;
            m_wren_d = wren1;
        end
    end

    // Tag stage k is live in cycle T+1+k; the last stage is the rvalid cycle, so rdata
    // captures m_q on the edge where stage RD_LAT-1 advances into it.
    always_comb begin
        tvld_d  = {tvld_q[RD_LAT-1:0], rd_accept};
        tport_d = {tport_q[RD_LAT-1:0], xfer1};
        rdata_d = rdata_q;
        if (tvld_q[RD_LAT-1]) begin
            rdata_d = m_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            streak_q <= '0;
            m_addr_q <= '0;
            m_data_q <= '0;
            m_wren_q <= 1'b0;
            rdata_q  <= '0;
            tvld_q   <= '0;
            tport_q  <= '0;
        end else begin
            streak_q <= streak_d;
            m_addr_q <= m_addr_d;
            m_data_q <= m_data_d;
            m_wren_q <= m_wren_d;
            rdata_q  <= rdata_d;
            tvld_q   <= tvld_d;
            tport_q  <= tport_d;
        end
    end

    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;
    assign m_wren  = m_wren_q;
    assign rdata   = rdata_q;
    assign rvalid0 = tvld_q[RD_LAT] & ~tport_q[RD_LAT];
    assign rvalid1 = tvld_q[RD_LAT] & tport_q[RD_LAT];

endmodule
